// File: rtl/background_scroll_renderer.sv
// Tile background layer with per-frame fine scroll. It uses a three-stage block-RAM fetch pipeline:
// nametable read, then pattern-line read, then colour output.
module background_scroll_renderer #(
    parameter int                         VRAM_ADDR_WIDTH = 12,
    parameter logic [VRAM_ADDR_WIDTH-1:0] PMB_BASE        = 12'h200,
    parameter logic [VRAM_ADDR_WIDTH-1:0] NTBL_BASE       = 12'h400,
    parameter logic [VRAM_ADDR_WIDTH-1:0] CTRL_BASE       = 12'h800,
    parameter int                         NT_ROWS         = 30
) (
    input  logic                       gpu_clk,
    input  logic                       rst_n,
    input  logic                       pixel_valid_in,
    input  logic [7:0]                 current_x,
    input  logic [7:0]                 current_y,
    input  logic                       vblank,
    input  logic [7:0]                 data_in,
    input  logic [VRAM_ADDR_WIDTH-1:0] address,
    input  logic                       write_enable,
    output logic [1:0]                 r,
    output logic [1:0]                 g,
    output logic [1:0]                 b,
    output logic                       pixel_valid_out
);

    localparam logic [VRAM_ADDR_WIDTH-1:0] PMB_BYTES  = VRAM_ADDR_WIDTH'(512);
    localparam logic [VRAM_ADDR_WIDTH-1:0] NTBL_BYTES = VRAM_ADDR_WIDTH'(1024);
    localparam logic [VRAM_ADDR_WIDTH-1:0] CTRL_BYTES = VRAM_ADDR_WIDTH'(4);
    localparam logic [8:0]                 WRAP_ROWS  = 9'(NT_ROWS * 8);
    localparam logic [9:0]                 PALETTE_IX = 10'd960;

    // Write-port window decode. An address below a base wraps to a large offset, so it fails the size test.
    logic [VRAM_ADDR_WIDTH-1:0] pmb_off;
    logic [VRAM_ADDR_WIDTH-1:0] ntbl_off;
    logic [VRAM_ADDR_WIDTH-1:0] ctrl_off;
    logic                       pmb_we;
    logic                       ntbl_we;
    logic                       ctrl_we;

    assign pmb_off  = address - PMB_BASE;
    assign ntbl_off = address - NTBL_BASE;
    assign ctrl_off = address - CTRL_BASE;
    assign pmb_we   = write_enable && (pmb_off < PMB_BYTES);
    assign ntbl_we  = write_enable && (ntbl_off < NTBL_BYTES);
    assign ctrl_we  = write_enable && (ctrl_off < CTRL_BYTES);

    logic [7:0] scroll_x_shadow_reg;
    logic [7:0] scroll_y_shadow_reg;
    logic [7:0] scroll_x_reg;
    logic [7:0] scroll_y_reg;
    logic [1:0] ctrl_reg;

    logic       s1_valid_reg;
    logic       s2_valid_reg;
    logic [7:0] tile_reg;
    logic [2:0] fx_reg;
    logic [2:0] fy_reg;
    logic [2:0] px_reg;
    logic [2:0] colour_reg;
    logic [5:0] palette_reg;

    // Stage 1: scrolled world coordinates and the nametable address.
    logic [7:0] wx;
    logic [8:0] sum_y;
    logic [7:0] wy;
    logic [9:0] ntbl_rd_addr;

    assign wx    = current_x + scroll_x_reg;
    assign sum_y = {1'b0, current_y} + {1'b0, scroll_y_reg};

    always_comb begin
        wy = sum_y[7:0];
        if (!ctrl_reg[1] && (sum_y >= WRAP_ROWS)) begin
            wy = 8'(sum_y - WRAP_ROWS);
        end
    end

    assign ntbl_rd_addr = {wy[7:3], wx[7:3]};

    // The nametable, with a registered read. palette_reg shadows entry 960 so stage 2 needs no second read port.
    logic [7:0] ntbl [1024];

    always_ff @(posedge gpu_clk) begin
        if (ntbl_we) begin
            ntbl[ntbl_off[9:0]] <= data_in;
        end
        if (ntbl_we && ntbl_off[9:0] == PALETTE_IX) begin
            palette_reg <= data_in[5:0];
        end
        tile_reg <= ntbl[ntbl_rd_addr];
    end

    // Stage 2: pattern memory is split into even and odd byte banks, so both line bytes are read in one cycle.
    logic [2:0]  py;
    logic [7:0]  pmb_rd_addr;
    logic [15:0] line;

    assign py          = tile_reg[5] ? ~fy_reg : fy_reg;
    assign pmb_rd_addr = {tile_reg[4:0], py};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pmb_bank
            logic [7:0] bank [256];
            logic [7:0] rd_reg;

            always_ff @(posedge gpu_clk) begin
                if (pmb_we && (pmb_off[0] == 1'(gi))) begin
                    bank[pmb_off[8:1]] <= data_in;
                end
                rd_reg <= bank[pmb_rd_addr];
            end
        end
    endgenerate

    assign line = {g_pmb_bank[0].rd_reg, g_pmb_bank[1].rd_reg};

    // Datapath registers that travel alongside the valid bits. They need no reset.
    always_ff @(posedge gpu_clk) begin
        fx_reg     <= wx[2:0];
        fy_reg     <= wy[2:0];
        px_reg     <= tile_reg[6] ? ~fx_reg : fx_reg;
        colour_reg <= tile_reg[7] ? palette_reg[5:3] : palette_reg[2:0];
    end

    // Stage 3: the two bits at 2*(7-px), which equals 2*~px for a 3-bit px.
    logic [1:0] pixel;

    assign pixel = line[{~px_reg, 1'b0} +: 2];

    always_ff @(posedge gpu_clk) begin
        if (!rst_n) begin
            s1_valid_reg        <= 1'b0;
            s2_valid_reg        <= 1'b0;
            pixel_valid_out     <= 1'b0;
            r                   <= 2'b00;
            g                   <= 2'b00;
            b                   <= 2'b00;
            scroll_x_shadow_reg <= 8'h00;
            scroll_y_shadow_reg <= 8'h00;
            scroll_x_reg        <= 8'h00;
            scroll_y_reg        <= 8'h00;
            ctrl_reg            <= 2'b01;
        end else begin
            s1_valid_reg    <= pixel_valid_in;
            s2_valid_reg    <= s1_valid_reg;
            pixel_valid_out <= s2_valid_reg;

            if (s2_valid_reg && ctrl_reg[0]) begin
                r <= pixel & {2{colour_reg[2]}};
                g <= pixel & {2{colour_reg[1]}};
                b <= pixel & {2{colour_reg[0]}};
            end else begin
                r <= 2'b00;
                g <= 2'b00;
                b <= 2'b00;
            end

            // The active scroll changes only in vblank with the pipeline drained, so a frame never tears.
            if (vblank && !s1_valid_reg && !s2_valid_reg && !pixel_valid_out) begin
                scroll_x_reg <= scroll_x_shadow_reg;
                scroll_y_reg <= scroll_y_shadow_reg;
            end

            if (ctrl_we) begin
                case (ctrl_off[1:0])
                    2'd0:    scroll_x_shadow_reg <= data_in;
                    2'd1:    scroll_y_shadow_reg <= data_in;
                    2'd2:    ctrl_reg            <= data_in[1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_background_scroll_renderer.sv
// Self-checking bench for background_scroll_renderer. It runs directed table rows and hand sequences,
// then random traffic, all compared against an arithmetic reference model.
module tb_background_scroll_renderer;

    logic        gpu_clk = 1'b0;
    logic        rst_n;
    logic        pixel_valid_in;
    logic [7:0]  current_x;
    logic [7:0]  current_y;
    logic        vblank;
    logic [7:0]  data_in;
    logic [11:0] address;
    logic        write_enable;
    logic [1:0]  r, g, b;
    logic        pixel_valid_out;

    always #5 gpu_clk = ~gpu_clk;

    background_scroll_renderer dut (
        .gpu_clk         (gpu_clk),
        .rst_n           (rst_n),
        .pixel_valid_in  (pixel_valid_in),
        .current_x       (current_x),
        .current_y       (current_y),
        .vblank          (vblank),
        .data_in         (data_in),
        .address         (address),
        .write_enable    (write_enable),
        .r               (r),
        .g               (g),
        .b               (b),
        .pixel_valid_out (pixel_valid_out)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [7:0] pmb_m  [512];
    logic [7:0] ntbl_m [1024];
    int         shx_m, shy_m, ax_m, ay_m;
    logic [1:0] ctrl_m;

    typedef struct packed {
        logic       v;
        logic [5:0] rgb;
    } out_t;
    out_t pipe_m [3];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Colour of one screen pixel, worked out directly from the scroll, tile and pattern rules.
    function automatic logic [5:0] ref_px(input int x, input int y);
        int wx, wy, sum, tile, pat, py, px, line, pix, col, pal;
        wx  = (x + ax_m) % 256;
        sum = y + ay_m;
        if (ctrl_m[1])     wy = sum % 256;
        else if (sum >= 240) wy = sum - 240;
        else               wy = sum;
        tile = int'(ntbl_m[(wy / 8) * 32 + wx / 8]);
        pat  = tile % 32;
        py   = ((tile & 32) != 0) ? 7 - wy % 8 : wy % 8;
        px   = ((tile & 64) != 0) ? 7 - wx % 8 : wx % 8;
        line = int'(pmb_m[pat * 16 + py * 2]) * 256 + int'(pmb_m[pat * 16 + py * 2 + 1]);
        pix  = (line >> (2 * (7 - px))) & 3;
        pal  = int'(ntbl_m[960]);
        col  = ((tile & 128) != 0) ? (pal >> 3) & 7 : pal & 7;
        return {2'(((col & 4) != 0) ? pix : 0), 2'(((col & 2) != 0) ? pix : 0), 2'(((col & 1) != 0) ? pix : 0)};
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [7:0] d);
        int ia;
        ia = int'(a);
        if (ia >= 'h200 && ia < 'h400)      pmb_m[ia - 'h200]  = d;
        else if (ia >= 'h400 && ia < 'h800) ntbl_m[ia - 'h400] = d;
        else if (ia == 'h800)               shx_m = int'(d);
        else if (ia == 'h801)               shy_m = int'(d);
        else if (ia == 'h802)               ctrl_m = d[1:0];
    endtask

    // Runs one clock cycle. It drives inputs, advances the model, then compares outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y, input logic vb,
                        input logic we, input logic [11:0] a, input logic [7:0] d, input logic rs);
        out_t np;
        logic empty;
        pixel_valid_in = v;
        current_x      = x;
        current_y      = y;
        vblank         = vb;
        write_enable   = we;
        address        = a;
        data_in        = d;
        rst_n          = rs;
        @(posedge gpu_clk);
        if (!rs) begin
            for (int i = 0; i < 3; i++) pipe_m[i] = '0;
            shx_m = 0; shy_m = 0; ax_m = 0; ay_m = 0;
            ctrl_m = 2'b01;
        end else begin
            np.v   = v;
            np.rgb = v ? ref_px(int'(x), int'(y)) : 6'd0;
            empty  = !(pipe_m[0].v || pipe_m[1].v || pipe_m[2].v);
            pipe_m[2] = pipe_m[1];
            if (!ctrl_m[0]) pipe_m[2].rgb = 6'd0;
            pipe_m[1] = pipe_m[0];
            pipe_m[0] = np;
            if (vb && empty) begin
                ax_m = shx_m;
                ay_m = shy_m;
            end
            if (we) model_write(a, d);
        end
        #1;
        check("valid", {7'd0, pixel_valid_out}, {7'd0, pipe_m[2].v});
        check("rgb", {2'b00, r, g, b}, {2'b00, pipe_m[2].rgb});
    endtask

    task automatic idle(input logic vb);
        step(1'b0, 8'd0, 8'd0, vb, 1'b0, 12'd0, 8'd0, 1'b1);
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, a, d, 1'b1);
    endtask

    task automatic pix(input logic [7:0] x, input logic [7:0] y);
        step(1'b1, x, y, 1'b0, 1'b0, 12'd0, 8'd0, 1'b1);
    endtask

    task automatic run_bubbles(output int vcnt, output int nz);
        vcnt = 0;
        nz   = 0;
        for (int i = 0; i < 16; i++) begin
            pix(8'(i * 3), 8'(i));
            if (pixel_valid_out) vcnt++;
            if ({r, g, b} != 6'd0) nz++;
            if (i % 5 == 4) begin
                for (int k = 0; k < 2; k++) begin
                    idle(1'b0);
                    if (pixel_valid_out) vcnt++;
                    if ({r, g, b} != 6'd0) nz++;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            if (pixel_valid_out) vcnt++;
            if ({r, g, b} != 6'd0) nz++;
        end
    endtask

    typedef struct {
        logic [9:0] ta;
        logic [7:0] tile;
        logic [8:0] pa;
        logic [7:0] phi, plo, pal, sx, sy, ctrl, x, y;
        logic [5:0] rgb;
    } row_t;

    row_t rows [11];

    initial begin
        int vcnt, nz;

        rows[0]  = '{10'd0,   8'h00, 9'd0,   8'hC0, 8'h00, 8'h07, 8'd0,   8'h00, 8'h01, 8'd0,  8'd0,   6'b111111};
        rows[1]  = '{10'd0,   8'h00, 9'd0,   8'hC0, 8'h00, 8'h07, 8'd0,   8'h00, 8'h01, 8'd1,  8'd0,   6'b000000};
        rows[2]  = '{10'd0,   8'h40, 9'd0,   8'hC0, 8'h00, 8'h07, 8'd0,   8'h00, 8'h01, 8'd7,  8'd0,   6'b111111};
        rows[3]  = '{10'd0,   8'h40, 9'd0,   8'hC0, 8'h00, 8'h07, 8'd0,   8'h00, 8'h01, 8'd0,  8'd0,   6'b000000};
        rows[4]  = '{10'd0,   8'h20, 9'd14,  8'hC0, 8'h00, 8'h07, 8'd0,   8'h00, 8'h01, 8'd0,  8'd0,   6'b111111};
        rows[5]  = '{10'd33,  8'h01, 9'd16,  8'h80, 8'h00, 8'h05, 8'h08, 8'hF8, 8'h01, 8'd0,  8'd0,   6'b100010};
        rows[6]  = '{10'd961, 8'h02, 9'd46,  8'hC0, 8'h00, 8'h07, 8'h08, 8'hF8, 8'h01, 8'd0,  8'd239, 6'b111111};
        rows[7]  = '{10'd0,   8'h03, 9'd60,  8'h40, 8'h00, 8'h07, 8'd0,   8'd16,  8'h01, 8'd0,  8'd230, 6'b010101};
        rows[8]  = '{10'd960, 8'h07, 9'd124, 8'hC0, 8'h00, 8'h07, 8'd0,   8'd16,  8'h03, 8'd0,  8'd230, 6'b111111};
        rows[9]  = '{10'd0,   8'h84, 9'd64,  8'h00, 8'hC0, 8'h2F, 8'd250, 8'd0,   8'h01, 8'd10, 8'd0,   6'b110011};
        rows[10] = '{10'd0,   8'h84, 9'd64,  8'h00, 8'hC0, 8'h2F, 8'd250, 8'd0,   8'h00, 8'd10, 8'd0,   6'b000000};

        for (int i = 0; i < 512; i++)  pmb_m[i]  = 8'h00;
        for (int i = 0; i < 1024; i++) ntbl_m[i] = 8'h00;
        for (int i = 0; i < 3; i++)    pipe_m[i] = '0;
        shx_m = 0; shy_m = 0; ax_m = 0; ay_m = 0; ctrl_m = 2'b01;

        // Reset state, then clear VRAM so the model and the DUT start from the same contents.
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 12'd0, 8'd0, 1'b0);
        step(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 12'd0, 8'd0, 1'b0);
        check("rst_valid", {7'd0, pixel_valid_out}, 8'd0);
        check("rst_rgb", {2'b00, r, g, b}, 8'd0);
        for (int i = 0; i < 512; i++)  wr(12'h200 + 12'(i), 8'h00);
        for (int i = 0; i < 1024; i++) wr(12'h400 + 12'(i), 8'h00);

        // The first valid pixel shows up exactly three cycles later.
        pix(8'd0, 8'd0);
        check("lat1", {7'd0, pixel_valid_out}, 8'd0);
        idle(1'b0);
        check("lat2", {7'd0, pixel_valid_out}, 8'd0);
        idle(1'b0);
        check("lat3", {7'd0, pixel_valid_out}, 8'd1);
        idle(1'b0);

        // Directed rows: tile, flips, palette select, scroll wrap and the enable bit.
        foreach (rows[i]) begin
            wr(12'h400 + 12'(rows[i].ta), rows[i].tile);
            wr(12'h200 + 12'(rows[i].pa), rows[i].phi);
            wr(12'h200 + 12'(rows[i].pa) + 12'd1, rows[i].plo);
            wr(12'h7C0, rows[i].pal);
            wr(12'h800, rows[i].sx);
            wr(12'h801, rows[i].sy);
            wr(12'h802, rows[i].ctrl);
            idle(1'b1);
            idle(1'b1);
            pix(rows[i].x, rows[i].y);
            idle(1'b0);
            idle(1'b0);
            check($sformatf("row%0d", i), {2'b00, r, g, b}, {2'b00, rows[i].rgb});
        end

        // Shadow scroll written mid-frame, then a vblank while pixels are still in flight: no latch yet.
        wr(12'h802, 8'h01);
        wr(12'h800, 8'h00);
        wr(12'h801, 8'h00);
        idle(1'b1);
        idle(1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(i), 8'(i), (i >= 8), (i == 4 || i == 5),
                 (i == 4) ? 12'h800 : 12'h801, (i == 4) ? 8'h08 : 8'hF8, 1'b1);
        end
        pix(8'd0, 8'd0);
        idle(1'b0);
        idle(1'b0);
        check("mid_hold", {2'b00, r, g, b}, 8'h00);
        idle(1'b1);
        idle(1'b1);
        pix(8'd0, 8'd0);
        idle(1'b0);
        idle(1'b0);
        check("mid_latched", {2'b00, r, g, b}, 8'h2A);

        // Valid pattern with bubbles, first enabled and then disabled.
        run_bubbles(vcnt, nz);
        check("bubble_count", 8'(vcnt), 8'd16);
        wr(12'h802, 8'h00);
        run_bubbles(vcnt, nz);
        check("dis_count", 8'(vcnt), 8'd16);
        check("dis_rgb", 8'(nz), 8'd0);

        // Reset with pixels in flight drops them and restores scroll and ctrl.
        pix(8'd1, 8'd1);
        pix(8'd2, 8'd2);
        step(1'b1, 8'd3, 8'd3, 1'b0, 1'b0, 12'd0, 8'd0, 1'b0);
        check("rst_flush", {7'd0, pixel_valid_out}, 8'd0);
        idle(1'b0);
        idle(1'b0);
        check("rst_drop", {7'd0, pixel_valid_out}, 8'd0);
        pix(8'd0, 8'd0);
        idle(1'b0);
        idle(1'b0);
        check("rst_scroll", {1'b0, pixel_valid_out, r, g, b}, 8'h40);

        // Random VRAM contents, then random traffic with control writes and stray writes.
        for (int i = 0; i < 512; i++)  wr(12'h200 + 12'(i), 8'($urandom));
        for (int i = 0; i < 1024; i++) wr(12'h400 + 12'(i), 8'($urandom));
        for (int round = 0; round < 3; round++) begin
            wr(12'h800, 8'($urandom));
            wr(12'h801, 8'($urandom));
            wr(12'h802, {6'd0, 1'($urandom), 1'b1});
            idle(1'b1);
            idle(1'b1);
            for (int c = 0; c < 400; c++) begin
                logic        we;
                logic [11:0] a;
                we = ($urandom_range(0, 9) == 0);
                case ($urandom_range(0, 2))
                    0:       a = 12'h800 + 12'($urandom_range(0, 3));
                    1:       a = 12'($urandom_range(0, 'h1FF));
                    default: a = 12'($urandom_range('h804, 'hFFF));
                endcase
                step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom_range(0, 239)),
                     ($urandom_range(0, 7) == 0), we, a, 8'($urandom), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
